ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_pkg.sv | 34 +++
 rtl/ex_if.sv | 41 ++++
 rtl/ex_alu_ctl.sv | 31 +++
 rtl/ex_stage.sv | 144 ++++++++++++++
 tb/tb_ex_stage.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared constants and types for the EX pipeline stage: ALU decode codes,
// internal ALU operations and the EX control FSM states.
package ex_pkg;

  localparam int unsigned MUL_CYCLES_DEF = 32;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL,
    ALU_NOP
  } alu_op_e;

  typedef enum logic {
    ST_RUN,
    ST_MUL
  } state_e;

endpackage

// File: rtl/ex_if.sv
// ID/EX input bundle and EX/MEM output bundle of the EX stage.
// master = upstream/ID side driving the bundle, slave = the EX stage.
interface ex_if;
  logic        in_valid;
  logic        flush;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npc;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] s_extend;
  logic [4:0]  instr_2016;
  logic [4:0]  instr_1511;

  logic        stall;
  logic        out_valid;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [31:0] add_result;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  muxout;

  modport master (
    output in_valid, flush, wb_ctl, m_ctl, regdst, alusrc, aluop,
           npc, rdata1, rdata2, s_extend, instr_2016, instr_1511,
    input  stall, out_valid, wb_ctlout, m_ctlout, add_result, zero,
           alu_result, rdata2out, muxout
  );

  modport slave (
    input  in_valid, flush, wb_ctl, m_ctl, regdst, alusrc, aluop,
           npc, rdata1, rdata2, s_extend, instr_2016, instr_1511,
    output stall, out_valid, wb_ctlout, m_ctlout, add_result, zero,
           alu_result, rdata2out, muxout
  );
endinterface

// File: rtl/ex_alu_ctl.sv
// ALU control: maps the 2-bit aluop and the R-type funct field onto the
// internal ALU operation.
module alu_ctl
  import ex_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output alu_op_e    alu_op
);

  always_comb begin
    alu_op = ALU_NOP;
    case (aluop)
      ALUOP_ADD: alu_op = ALU_ADD;
      ALUOP_SUB: alu_op = ALU_SUB;
      ALUOP_OR:  alu_op = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_SUB: alu_op = ALU_SUB;
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_SLT: alu_op = ALU_SLT;
          FUNCT_MUL: alu_op = ALU_MUL;
          default:   alu_op = ALU_NOP;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// EX pipeline stage: single-cycle ALU plus an iterative shift-add multiplier
// that stalls upstream while it runs; results land in the EX/MEM register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
  input logic clk,
  input logic rst_n,
  ex_if.slave bus
);

  localparam int unsigned CW = $clog2(MUL_CYCLES + 1);

  state_e      state, state_n;
  alu_op_e     alu_op;
  logic [31:0] b_op;
  logic [31:0] alu_comb;
  logic [31:0] add_comb;
  logic [4:0]  mux_comb;
  logic        is_mul;

  logic [CW-1:0] cnt;
  logic [31:0]   mcand, mplier, acc, acc_next;
  logic [1:0]    p_wb;
  logic [2:0]    p_m;
  logic [31:0]   p_add, p_rd2;
  logic [4:0]    p_mux;

  alu_ctl u_alu_ctl (
    .aluop  (bus.aluop),
    .funct  (bus.s_extend[5:0]),
    .alu_op (alu_op)
  );

  assign b_op     = bus.alusrc ? bus.s_extend : bus.rdata2;
  assign add_comb = bus.npc + (bus.s_extend << 2);
  assign mux_comb = bus.regdst ? bus.instr_1511 : bus.instr_2016;
  assign is_mul   = (alu_op == ALU_MUL);
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_comb = '0;
    case (alu_op)
      ALU_ADD: alu_comb = bus.rdata1 + b_op;
      ALU_SUB: alu_comb = bus.rdata1 - b_op;
      ALU_AND: alu_comb = bus.rdata1 & b_op;
      ALU_OR:  alu_comb = bus.rdata1 | b_op;
      ALU_SLT: alu_comb = ($signed(bus.rdata1) < $signed(b_op)) ? 32'd1 : 32'd0;
      default: alu_comb = '0;
    endcase
  end

  assign bus.stall = (state == ST_MUL);
  assign bus.zero  = (bus.alu_result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (bus.flush) begin
      state_n = ST_RUN;
    end else begin
      case (state)
        ST_RUN: if (bus.in_valid && is_mul) state_n = ST_MUL;
        ST_MUL: if (cnt == CW'(1))         state_n = ST_RUN;
        default: state_n = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      p_wb           <= '0;
      p_m            <= '0;
      p_add          <= '0;
      p_rd2          <= '0;
      p_mux          <= '0;
      bus.out_valid  <= 1'b0;
      bus.wb_ctlout  <= '0;
      bus.m_ctlout   <= '0;
      bus.add_result <= '0;
      bus.alu_result <= '0;
      bus.rdata2out  <= '0;
      bus.muxout     <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      cnt           <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!bus.in_valid) begin
            bus.out_valid <= 1'b0;
          end else if (is_mul) begin
            // Control side of the bundle is parked until the product is done.
            mcand         <= bus.rdata1;
            mplier        <= b_op;
            acc           <= '0;
            cnt           <= CW'(MUL_CYCLES);
            p_wb          <= bus.wb_ctl;
            p_m           <= bus.m_ctl;
            p_add         <= add_comb;
            p_rd2         <= bus.rdata2;
            p_mux         <= mux_comb;
            bus.out_valid <= 1'b0;
          end else begin
            bus.wb_ctlout  <= bus.wb_ctl;
            bus.m_ctlout   <= bus.m_ctl;
            bus.add_result <= add_comb;
            bus.alu_result <= alu_comb;
            bus.rdata2out  <= bus.rdata2;
            bus.muxout     <= mux_comb;
            bus.out_valid  <= 1'b1;
          end
        end
        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          // Final step's partial sum goes straight into the result register.
          if (cnt == CW'(1)) begin
            bus.wb_ctlout  <= p_wb;
            bus.m_ctlout   <= p_m;
            bus.add_result <= p_add;
            bus.alu_result <= acc_next;
            bus.rdata2out  <= p_rd2;
            bus.muxout     <= p_mux;
            bus.out_valid  <= 1'b1;
          end
        end
        default: bus.out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table of single-cycle ALU vectors plus hand-written
// multiply, flush and reset sequences, all checked through an expected-result queue.
module tb_ex_stage;
  import ex_pkg::*;

  typedef struct {
    logic [1:0]  aluop;
    logic        alusrc;
    logic        regdst;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] sext;
    logic [31:0] npc;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] e_alu;
    logic [31:0] e_add;
    logic        e_zero;
    logic [4:0]  e_mux;
  } vec_t;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] add;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] rd2;
    logic [4:0]  mux;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  vec_t tbl[13];
  vec_t mulv;

  ex_if bus ();

  ex_stage #(.MUL_CYCLES(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic drive(input vec_t v, input int id, input bit push);
    bus.in_valid   = 1'b1;
    bus.aluop      = v.aluop;
    bus.alusrc     = v.alusrc;
    bus.regdst     = v.regdst;
    bus.rdata1     = v.r1;
    bus.rdata2     = v.r2;
    bus.s_extend   = v.sext;
    bus.npc        = v.npc;
    bus.instr_2016 = v.rt;
    bus.instr_1511 = v.rd;
    bus.wb_ctl     = 2'(id);
    bus.m_ctl      = 3'(id);
    if (push)
      exp_q.push_back('{2'(id), 3'(id), v.e_add, v.e_alu, v.e_zero, v.r2, v.e_mux, id});
  endtask

  // Scoreboard: every out_valid cycle must consume exactly one expected record.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got out_valid=1 alu_result=%h, required no output", bus.alu_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({bus.wb_ctlout, bus.m_ctlout, bus.add_result, bus.alu_result, bus.zero, bus.rdata2out, bus.muxout}
            !== {e.wb, e.m, e.add, e.alu, e.zero, e.rd2, e.mux}) begin
          fails++;
          $display("FAIL result_vec%0d: got wb=%h m=%h add=%h alu=%h zero=%b rd2=%h mux=%h, required wb=%h m=%h add=%h alu=%h zero=%b rd2=%h mux=%h",
                   e.id, bus.wb_ctlout, bus.m_ctlout, bus.add_result, bus.alu_result, bus.zero, bus.rdata2out, bus.muxout,
                   e.wb, e.m, e.add, e.alu, e.zero, e.rd2, e.mux);
        end
      end
    end
  end

  initial begin
    tbl[0]  = '{2'b10, 1'b0, 1'b1, 32'd5, 32'd7, 32'h20, 32'h0, 5'd9, 5'd3, 32'd12, 32'h80, 1'b0, 5'd3};
    tbl[1]  = '{2'b01, 1'b0, 1'b0, 32'd9, 32'd9, 32'd4, 32'h100, 5'd5, 5'd7, 32'd0, 32'h110, 1'b1, 5'd5};
    tbl[2]  = '{2'b10, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'h2A, 32'h0, 5'd1, 5'd4, 32'd1, 32'hA8, 1'b0, 5'd4};
    tbl[3]  = '{2'b10, 1'b0, 1'b1, 32'd1, 32'hFFFFFFFF, 32'h2A, 32'h0, 5'd1, 5'd4, 32'd0, 32'hA8, 1'b1, 5'd4};
    tbl[4]  = '{2'b10, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'h2A, 32'h0, 5'd2, 5'd6, 32'd0, 32'hA8, 1'b1, 5'd6};
    tbl[5]  = '{2'b10, 1'b0, 1'b1, 32'd3, 32'd5, 32'h22, 32'h0, 5'd2, 5'd8, 32'hFFFFFFFE, 32'h88, 1'b0, 5'd8};
    tbl[6]  = '{2'b10, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'h24, 32'h0, 5'd0, 5'd10, 32'hF000, 32'h90, 1'b0, 5'd10};
    tbl[7]  = '{2'b10, 1'b0, 1'b1, 32'hF0F0, 32'h0F0F, 32'h25, 32'h0, 5'd0, 5'd11, 32'hFFFF, 32'h94, 1'b0, 5'd11};
    tbl[8]  = '{2'b10, 1'b0, 1'b1, 32'd1, 32'd2, 32'h3F, 32'h0, 5'd0, 5'd12, 32'd0, 32'hFC, 1'b1, 5'd12};
    tbl[9]  = '{2'b00, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h55, 32'd2, 32'h10, 5'd13, 5'd14, 32'd1, 32'h18, 1'b0, 5'd13};
    tbl[10] = '{2'b11, 1'b1, 1'b0, 32'h1200, 32'h77, 32'h34, 32'h20, 5'd15, 5'd16, 32'h1234, 32'hF0, 1'b0, 5'd15};
    tbl[11] = '{2'b00, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'd0, 32'h44, 5'd17, 5'd18, 32'd0, 32'h44, 1'b1, 5'd17};
    tbl[12] = '{2'b01, 1'b1, 1'b0, 32'd0, 32'h99, 32'hFFFFFFFF, 32'h100, 5'd19, 5'd20, 32'd1, 32'hFC, 1'b0, 5'd19};
    mulv    = '{2'b10, 1'b0, 1'b1, 32'h10000, 32'h10001, 32'h18, 32'h0, 5'd1, 5'd21, 32'h00010000, 32'h60, 1'b0, 5'd21};

    rst_n = 1'b0;
    idle();
    drive(tbl[0], 0, 1'b0);
    bus.in_valid = 1'b0;
    #12;
    check("reset_outputs",
          128'({bus.out_valid, bus.stall, bus.zero, bus.wb_ctlout, bus.m_ctlout, bus.add_result, bus.alu_result, bus.rdata2out, bus.muxout}),
          128'({1'b0, 1'b0, 1'b1, 2'b0, 3'b0, 32'h0, 32'h0, 32'h0, 5'h0}));
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle operations
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i], i, 1'b1);
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    check("idle_out_valid_low", 128'(bus.out_valid), 128'(1'b0));
    check("idle_result_holds", 128'(bus.alu_result), 128'(tbl[12].e_alu));

    // Multiply: stall for 32 cycles, inputs presented meanwhile are ignored
    drive(mulv, 100, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      check($sformatf("mul_stall_c%0d", i), 128'(bus.stall), 128'(1'b1));
      if (i < 32) drive(tbl[5], 200, 1'b0);
      else        idle();
    end
    @(negedge clk);
    check("mul_stall_released", 128'(bus.stall), 128'(1'b0));
    check("mul_out_valid", 128'(bus.out_valid), 128'(1'b1));
    #1;
    check("mul_result_consumed", 128'(exp_q.size()), 128'(0));

    // Flush at cycle 10 of a multiply, together with a new valid input
    @(negedge clk);
    drive(mulv, 101, 1'b0);
    @(negedge clk);
    idle();
    repeat (9) @(negedge clk);
    drive(tbl[0], 102, 1'b0);
    bus.flush = 1'b1;
    @(negedge clk);
    idle();
    check("flush_stall_low", 128'(bus.stall), 128'(1'b0));
    check("flush_out_valid_low", 128'(bus.out_valid), 128'(1'b0));
    check("flush_result_holds", 128'(bus.alu_result), 128'(32'h00010000));
    repeat (34) @(negedge clk);
    check("flush_no_late_result", 128'(bus.alu_result), 128'(32'h00010000));
    drive(tbl[0], 3, 1'b1);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    check("post_flush_add_done", 128'(exp_q.size()), 128'(0));

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    drive(mulv, 104, 1'b1);
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midmul_reset_outputs",
          128'({bus.out_valid, bus.stall, bus.zero, bus.wb_ctlout, bus.m_ctlout, bus.add_result, bus.alu_result, bus.rdata2out, bus.muxout}),
          128'({1'b0, 1'b0, 1'b1, 2'b0, 3'b0, 32'h0, 32'h0, 32'h0, 5'h0}));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(tbl[1], 5, 1'b1);
    @(negedge clk);
    idle();
    check("after_reset_run_result", 128'(bus.add_result), 128'(32'h110));
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
